cic_decimator: RTL and testbench

//  Downstream digital stage of chiptop: consumes the 1-bit modulator bitstream on clk
//  and decimates it by R with an N-stage CIC (sinc^N) filter. Emits a signed PCM word

---
 rtl/cic_if.sv | 25 ++
 rtl/cic_decimator.sv | 116 +++++++++++
 tb/tb_cic_decimator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cic_if.sv
// Sample-side bundle of the CIC decimator: modulator bit in, PCM word and strobe out.
// With CIC_DBG_EN defined the bundle also carries the full-width comb output dout_raw.
interface cic_if #(
  parameter int unsigned OUT_W = 16
`ifdef CIC_DBG_EN
  , parameter int unsigned ACC_W = 22
`endif
);

  logic                    bit_in;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_valid;
`ifdef CIC_DBG_EN
  logic signed [ACC_W-1:0] dout_raw;
`endif

`ifdef CIC_DBG_EN
  modport master (output bit_in, input dout, input dout_valid, input dout_raw);
  modport slave  (input bit_in, output dout, output dout_valid, output dout_raw);
`else
  modport master (output bit_in, input dout, input dout_valid);
  modport slave  (input bit_in, output dout, output dout_valid);
`endif

endinterface

// File: rtl/cic_decimator.sv
// N-stage CIC (sinc^N) decimator by R for a 1-bit modulator stream, signed PCM output.
// Optional build macro CIC_DBG_EN adds the full-width comb output port dout_raw.
module cic_decimator #(
  parameter int unsigned R     = 80,
  parameter int unsigned N     = 3,
  parameter int unsigned ACC_W = 22,
  parameter int unsigned OUT_W = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  cic_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(R);
  localparam int unsigned WARM_W = $clog2(N + 1);
  localparam int unsigned SHIFT  = ACC_W - OUT_W;

  typedef logic signed [ACC_W-1:0] acc_t;

  if (R < 2) begin : g_bad_r
    $error("cic_decimator: R must be at least 2");
  end
  if (N < 1 || N > 5) begin : g_bad_n
    $error("cic_decimator: N must be in 1..5");
  end
  if (ACC_W < N * $clog2(R) + 1 || OUT_W > ACC_W) begin : g_bad_w
    $error("cic_decimator: ACC_W too narrow for R^N gain or narrower than OUT_W");
  end

  acc_t                    integ_q [N];
  acc_t                    dly_q   [N];
  acc_t                    comb_in [N];
  acc_t                    comb_out;
  acc_t                    x;
  logic [CNT_W-1:0]        cnt_q;
  logic [WARM_W-1:0]       warm_q;
  logic signed [OUT_W-1:0] dout_q;
  logic                    valid_q;
  logic                    strobe;

  assign x      = bus.bit_in ? acc_t'(1) : '1;
  assign strobe = en && (cnt_q == CNT_W'(R - 1));

  // comb_in[k] is the input of comb stage k+1, which is also what its delay stores.
  always_comb begin
    acc_t c;
    c = integ_q[N-1];
    for (int k = 0; k < N; k++) begin
      comb_in[k] = c;
      c          = c - dly_q[k];
    end
    comb_out = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      warm_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
    end else if (!en) begin
      // Partial frame and warm-up are discarded; dout keeps the last sample.
      cnt_q   <= '0;
      warm_q  <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
    end else begin
      integ_q[0] <= integ_q[0] + x;
      for (int k = 1; k < N; k++) begin
        integ_q[k] <= integ_q[k] + integ_q[k-1];
      end
      valid_q <= 1'b0;
      if (strobe) begin
        cnt_q <= '0;
        for (int k = 0; k < N; k++) begin
          dly_q[k] <= comb_in[k];
        end
        dout_q <= OUT_W'(comb_out >>> SHIFT);
        // The first N samples still carry comb start-up transients.
        if (warm_q == WARM_W'(N)) begin
          valid_q <= 1'b1;
        end else begin
          warm_q <= warm_q + WARM_W'(1);
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;

`ifdef CIC_DBG_EN
  acc_t raw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= '0;
    end else if (strobe) begin
      raw_q <= comb_out;
    end
  end

  assign bus.dout_raw = raw_q;
`endif

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: sample-level sinc^N model checked every cycle, plus
// hand-computed steady-state levels, warm-up timing and enable/reset behaviour.
module tb_cic_decimator;

  localparam int unsigned R     = 80;
  localparam int unsigned N     = 3;
  localparam int unsigned ACC_W = 22;
  localparam int unsigned OUT_W = 16;
  localparam int          FIRST = 320;

  logic clk;
  logic rst_n;
  logic en;

  cic_if #(.OUT_W(OUT_W)) bus ();

  cic_decimator #(
    .R     (R),
    .N     (N),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int en_edges = 0;

  longint                  xs[$];
  longint                  ss[$];
  logic signed [OUT_W-1:0] exp_dout;
  logic                    exp_valid;
  longint                  exp_raw;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic ok, input longint act, input longint req);
    n_total++;
    if (ok === 1'b1) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // Integrator cascade output after n inputs, as N nested running sums of the input history.
  function automatic longint integ_out();
    longint lvl[$];
    longint acc;
    lvl = xs;
    for (int k = 1; k < N; k++) begin
      acc = 0;
      for (int i = 0; i < lvl.size(); i++) begin
        longint t;
        t      = lvl[i];
        lvl[i] = acc;
        acc   += t;
      end
    end
    acc = 0;
    foreach (lvl[i]) acc += lvl[i];
    return acc;
  endfunction

  // N-th backward difference of the decimated sequence, earlier samples taken as zero.
  function automatic longint comb_out();
    longint y;
    longint b;
    int     idx;
    y = 0;
    b = 1;
    for (int k = 0; k <= N; k++) begin
      idx = ss.size() - 1 - k;
      if (idx >= 0) y += ((k % 2) ? -b : b) * ss[idx];
      b = b * (N - k) / (k + 1);
    end
    return y;
  endfunction

  function automatic logic pat(input int mode, input int k);
    case (mode)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return (k % 2) == 0;
      4:       return (k % 4) != 3;
      default: return 1'($urandom_range(1));
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        xs.delete();
        ss.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_raw   = 0;
      end else if (!en) begin
        xs.delete();
        ss.delete();
        exp_valid = 1'b0;
      end else begin
        exp_valid = 1'b0;
        if (xs.size() % R == R - 1) begin
          logic signed [ACC_W-1:0] w;
          longint y;
          ss.push_back(integ_out());
          y         = comb_out();
          w         = y[ACC_W-1:0];
          exp_raw   = longint'(w);
          exp_dout  = OUT_W'(w >>> (ACC_W - OUT_W));
          exp_valid = ss.size() > N;
        end
        xs.push_back(bus.bit_in ? 64'sd1 : -64'sd1);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || !en) en_edges = 0;
      else en_edges++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("dout_valid_model", bus.dout_valid == exp_valid, bus.dout_valid, exp_valid);
      chk("dout_model", bus.dout == exp_dout, bus.dout, exp_dout);
`ifdef CIC_DBG_EN
      chk("dout_raw_model", bus.dout_raw == ACC_W'(exp_raw), bus.dout_raw, exp_raw);
`endif
    end
  end

  task automatic phase(input int mode, input int ncyc, input longint lit, input int exp_n);
    int nval = 0;
    int last = -1;
    for (int i = 0; i < ncyc; i++) begin
      bus.bit_in = pat(mode, en_edges);
      @(negedge clk);
      if (bus.dout_valid === 1'b1) begin
        nval++;
        if (last < 0) chk("first_valid_edge", en_edges == FIRST, en_edges, FIRST);
        else chk("valid_spacing", (en_edges - last) == R, en_edges - last, R);
        last = en_edges;
        chk("dout_literal", bus.dout == lit, bus.dout, lit);
`ifdef CIC_DBG_EN
        if (mode == 1) chk("dout_raw_literal", bus.dout_raw == 512000, bus.dout_raw, 512000);
`endif
      end
    end
    chk("valid_count", nval == exp_n, nval, exp_n);
  endtask

  task automatic idle(input int ncyc, input bit chk_hold, input longint hold);
    int nval = 0;
    en = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      bus.bit_in = pat(0, i);
      @(negedge clk);
      if (bus.dout_valid !== 1'b0) nval++;
    end
    chk("idle_no_valid", nval == 0, nval, 0);
    if (chk_hold) chk("idle_dout_hold", bus.dout == hold, bus.dout, hold);
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    bus.bit_in = 1'b0;

    // Reset with en high and random input: outputs stay zero.
    for (int i = 0; i < 20; i++) begin
      bus.bit_in = pat(0, i);
      @(negedge clk);
    end
    chk("reset_dout", bus.dout == 0, bus.dout, 0);
    chk("reset_valid", bus.dout_valid == 1'b0, bus.dout_valid, 0);

    rst_n = 1'b1;
    phase(1, 645, 8000, 5);
    chk("full_scale_hex", bus.dout == 16'sh1F40, bus.dout, 16'sh1F40);
    idle(5, 1'b1, 8000);

    en = 1'b1;
    phase(2, 645, -8000, 5);
    idle(5, 1'b1, -8000);

    en = 1'b1;
    phase(3, 645, 0, 5);
    idle(5, 1'b1, 0);

    en = 1'b1;
    phase(4, 645, 4000, 5);
    idle(5, 1'b1, 4000);

    // Enable drop mid-frame: nothing valid until 320 en cycles after re-enable.
    en = 1'b1;
    phase(1, 150, 8000, 0);
    idle(50, 1'b0, 0);
    en = 1'b1;
    phase(1, 400, 8000, 2);
    idle(5, 1'b1, 8000);

    // Reset drop mid-frame behaves the same.
    en = 1'b1;
    phase(4, 170, 4000, 0);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("midreset_dout", bus.dout == 0, bus.dout, 0);
    chk("midreset_valid", bus.dout_valid == 1'b0, bus.dout_valid, 0);
    rst_n = 1'b1;
    phase(4, 400, 4000, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
